// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Arbitrates the single read/write port of the image SRAM between NUM_REQ
//   requesters (0: dithering engine, 1: MCU ingress loader, 2: MCU egress
//   reader). One access is granted per cycle. Locked bursts keep the grant
//   with one owner for up to MAX_BURST cycles. Read data is steered back to
//   the issuing requester through a RD_LATENCY-deep one-hot tag pipeline.
//
//   Build option: define ARB_ROUND_ROBIN_EN to rotate the arbitration
//   priority (the last granted requester becomes lowest). When it is not
//   defined, priority is fixed and index 0 is highest.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   req/we/lock          per-requester request, write select, burst lock
//   addr/wdata           flattened per-requester address / write data
//   gnt                  one-hot grant (combinational)
//   rvalid/rdata         read return; rdata is sram_q passed through
//   sram_addr/wdata/wren/rden, sram_q   SRAM port-A interface
//   busy                 lock held or reads in flight
module sram_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ-1:0]            lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_wdata,
  output logic                          sram_wren,
  output logic                          sram_rden,
  input  logic [DATA_WIDTH-1:0]         sram_q,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {ARB, LOCKED} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    owner_q, owner_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                excl_q, excl_d;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0]  tag_q;
  logic [ADDR_WIDTH-1:0]               addr_q;

  logic [NUM_REQ-1:0]                  excl_mask, cand;
  logic [IDX_W-1:0]                    start;
  logic [IDX_W-1:0]                    arb_idx, gnt_idx;
  logic                                arb_found, gnt_vld;
  int unsigned                         scan;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_last;

  always_ff @(posedge clk) begin
    if (rst)          rr_last <= IDX_W'(NUM_REQ - 1);
    else if (gnt_vld) rr_last <= gnt_idx;
  end

  assign start = (rr_last == IDX_W'(NUM_REQ - 1)) ? '0 : rr_last + 1'b1;
`else
  assign start = '0;
`endif

  // Candidate search. After a capped burst the previous owner is masked out
  // for one arbitration, unless it is the only requester.
  always_comb begin
    excl_mask = '0;
    if (excl_q) excl_mask = NUM_REQ'(1) << owner_q;
    cand = req & ~excl_mask;
    if (cand == '0) cand = req;
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = 32'(start) + i;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!arb_found && cand[scan]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    excl_d  = 1'b0;
    gnt_vld = 1'b0;
    gnt_idx = owner_q;
    if (state_q == LOCKED && req[owner_q]) begin
      gnt_vld = 1'b1;
      if (!lock[owner_q]) begin
        state_d = ARB;
        cnt_d   = '0;
      end else if (int'(cnt_q) + 1 >= MAX_BURST) begin
        state_d = ARB;
        cnt_d   = '0;
        excl_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // Plain arbitration, also taken the same cycle a locked owner drops req.
      state_d = ARB;
      cnt_d   = '0;
      if (arb_found) begin
        gnt_vld = 1'b1;
        gnt_idx = arb_idx;
        owner_d = arb_idx;
        if (lock[arb_idx]) begin
          if (MAX_BURST > 1) begin
            state_d = LOCKED;
            cnt_d   = CNT_W'(1);
          end else begin
            excl_d = 1'b1;
          end
        end
      end
    end
    if (rst) gnt_vld = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      owner_q <= '0;
      cnt_q   <= '0;
      excl_q  <= 1'b0;
      tag_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      excl_q  <= excl_d;
      tag_q[0] <= (gnt_vld && !we[gnt_idx]) ? (NUM_REQ'(1) << gnt_idx) : '0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      if (gnt_vld) addr_q <= addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    gnt        = gnt_vld ? (NUM_REQ'(1) << gnt_idx) : '0;
    sram_addr  = gnt_vld ? addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : addr_q;
    sram_wdata = wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    sram_wren  = gnt_vld & we[gnt_idx];
    sram_rden  = gnt_vld & ~we[gnt_idx];
    rvalid     = rst ? '0 : tag_q[RD_LATENCY-1];
    rdata      = sram_q;
    busy       = ~rst & ((state_q == LOCKED) | (tag_q != '0));
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, lock;
  logic [35:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata, sram_wdata, sram_q;
  logic [11:0] sram_addr;
  logic        sram_wren, sram_rden, busy;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [4096];
  logic [7:0] q1, q2;
  logic [2:0] col_exp [3];

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NUM_REQ(3), .ADDR_WIDTH(12), .DATA_WIDTH(8), .RD_LATENCY(2), .MAX_BURST(8)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock), .addr(addr),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wren(sram_wren),
    .sram_rden(sram_rden), .sram_q(sram_q), .busy(busy)
  );

  // Two-cycle-latency SRAM behaviour model.
  always @(posedge clk) begin
    if (sram_wren) mem[sram_addr] <= sram_wdata;
    q1 <= mem[sram_addr];
    q2 <= q1;
  end
  assign sram_q = q2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h005] = 8'h3C;
    mem[12'h006] = 8'h7F;
`ifdef ARB_ROUND_ROBIN_EN
    col_exp[0] = 3'b001; col_exp[1] = 3'b010; col_exp[2] = 3'b100;
`else
    col_exp[0] = 3'b001; col_exp[1] = 3'b001; col_exp[2] = 3'b001;
`endif
    rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    tick(); tick();

    // Reset state, with requests present.
    req = 3'b111;
    sample();
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_rden", sram_rden, 1'b0);
    chk("reset_wren", sram_wren, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rvalid", rvalid, 3'b000);
    tick();
    rst = 1'b0; req = '0;
    tick();

    // Priority collision.
    req = 3'b111; we = '0; lock = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      chk("collision_gnt", gnt, col_exp[c]);
      if (c == 2) chk("collision_rvalid", rvalid, 3'b001);
      tick();
    end
    req = '0;
    sample(); chk("drain_busy", busy, 1'b1); tick();
    tick();
    sample(); chk("idle_busy", busy, 1'b0); tick();

    // Read return tagging.
    addr[12 +: 12] = 12'h005;
    addr[24 +: 12] = 12'h006;
    req = 3'b010;
    sample();
    chk("tag_gnt1", gnt, 3'b010);
    chk("tag_rden", sram_rden, 1'b1);
    chk("tag_addr1", sram_addr, 12'h005);
    tick();
    req = 3'b100;
    sample();
    chk("tag_gnt2", gnt, 3'b100);
    chk("tag_addr2", sram_addr, 12'h006);
    tick();
    req = 3'b000;
    sample();
    chk("tag_rvalid1", rvalid, 3'b010);
    chk("tag_rdata1", rdata, 8'h3C);
    chk("idle_rden", sram_rden, 1'b0);
    chk("addr_hold", sram_addr, 12'h006);
    tick();
    sample();
    chk("tag_rvalid2", rvalid, 3'b100);
    chk("tag_rdata2", rdata, 8'h7F);
    tick();
    sample(); chk("tag_rvalid_end", rvalid, 3'b000); tick();

    // Burst cap with a competing requester.
    req = 3'b011; lock = 3'b001;
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("burst_cap_gnt", gnt, (c == 8) ? 3'b010 : 3'b001);
      tick();
    end
    req = '0; lock = '0;
    tick(); tick(); tick();

    // Burst cap with no competitor: owner re-granted at the cap.
    req = 3'b001; lock = 3'b001;
    for (int c = 0; c < 10; c++) begin
      sample();
      chk("burst_solo_gnt", gnt, 3'b001);
      tick();
    end
    req = '0; lock = '0;
    tick(); tick(); tick();

    // Lock release while a higher-priority requester waits (writes only).
    addr[0 +: 12] = 12'h010; addr[12 +: 12] = 12'h011;
    we = 3'b011; req = 3'b010; lock = 3'b010;
    sample(); chk("release_gnt0", gnt, 3'b010); tick();
    req = 3'b011;
    sample(); chk("release_gnt1", gnt, 3'b010); chk("locked_busy", busy, 1'b1); tick();
    sample(); chk("release_gnt2", gnt, 3'b010); tick();
    lock = 3'b000;
    sample(); chk("release_gnt3", gnt, 3'b010); tick();
    sample(); chk("release_gnt4", gnt, 3'b001); tick();
    req = '0; we = '0;
    sample(); chk("release_busy", busy, 1'b0); tick();

    // Reset in the middle of a read.
    addr[24 +: 12] = 12'h006;
    req = 3'b100;
    sample(); chk("rstmid_gnt", gnt, 3'b100); tick();
    rst = 1'b1;
    sample();
    chk("rstmid_gnt_rst", gnt, 3'b000);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_rvalid1", rvalid, 3'b000);
    tick();
    rst = 1'b0; req = '0;
    for (int c = 2; c < 5; c++) begin
      sample(); chk("rstmid_rvalid", rvalid, 3'b000); tick();
    end

    // Write then read of the same address.
    addr[12 +: 12] = 12'h0FF; wdata[8 +: 8] = 8'hAA;
    req = 3'b010; we = 3'b010;
    sample();
    chk("wr_wren", sram_wren, 1'b1);
    chk("wr_rden", sram_rden, 1'b0);
    chk("wr_addr", sram_addr, 12'h0FF);
    chk("wr_wdata", sram_wdata, 8'hAA);
    tick();
    addr[0 +: 12] = 12'h0FF;
    req = 3'b001; we = 3'b000;
    sample();
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_rden", sram_rden, 1'b1);
    chk("rd_wren", sram_wren, 1'b0);
    tick();
    req = '0;
    sample(); chk("raw_rvalid_early", rvalid, 3'b000); tick();
    sample();
    chk("raw_rvalid", rvalid, 3'b001);
    chk("raw_rdata", rdata, 8'hAA);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
